// File: rtl/zimbo_mem_arbiter.sv
// rtl/zimbo_mem_arbiter.sv - two-master arbiter for the Zimbo single-port memory
// Grants one access per cycle, registers the memory side, routes read data back to its owner.
module zimbo_mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] addrm,
  output logic [DW-1:0] wmdata,
  output logic          memwr_en,
  input  logic [DW-1:0] rmdata,
  output logic          busy,
  output logic [15:0]   acc_cnt
);

  logic            ptr;       // 0: m0 wins a tie, 1: m1 wins a tie
  logic            accept;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [RD_LAT:0] pipe_vld;  // bit 0 rides alongside addrm, bit RD_LAT meets rmdata
  logic [RD_LAT:0] pipe_own;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if ((FIXED_PRI != 0) || !ptr) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    accept    = m0_gnt || m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addrm    <= '0;
      wmdata   <= '0;
      memwr_en <= 1'b0;
      ptr      <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      memwr_en <= 1'b0;
      if (accept) begin
        addrm    <= sel_addr;
        wmdata   <= sel_wdata;
        memwr_en <= sel_we;
        ptr      <= m0_gnt;
        acc_cnt  <= acc_cnt + 16'd1;
      end
    end
  end

  // Ownership tags travel with each read so the returning data finds its requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld <= {pipe_vld[RD_LAT-1:0], accept && !sel_we};
      pipe_own <= {pipe_own[RD_LAT-1:0], m1_gnt};
    end
  end

  always_comb begin
    m0_rvalid = pipe_vld[RD_LAT] && !pipe_own[RD_LAT];
    m1_rvalid = pipe_vld[RD_LAT] &&  pipe_own[RD_LAT];
    m0_rdata  = rmdata;
    m1_rdata  = rmdata;
    busy      = |pipe_vld;
  end

endmodule

// File: tb/tb_zimbo_mem_arbiter.sv
// tb/tb_zimbo_mem_arbiter.sv - scoreboard bench for zimbo_mem_arbiter
// Instance 0: RD_LAT=1 round-robin; instance 1: RD_LAT=3 fixed priority.
module tb_zimbo_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_req [2];
  logic        m0_we [2];
  logic [15:0] m0_addr [2];
  logic [15:0] m0_wdata [2];
  logic        m0_gnt [2];
  logic        m0_rvalid [2];
  logic [15:0] m0_rdata [2];
  logic        m1_req [2];
  logic        m1_we [2];
  logic [15:0] m1_addr [2];
  logic [15:0] m1_wdata [2];
  logic        m1_gnt [2];
  logic        m1_rvalid [2];
  logic [15:0] m1_rdata [2];
  logic [15:0] addrm [2];
  logic [15:0] wmdata [2];
  logic        memwr_en [2];
  logic [15:0] rmdata [2];
  logic        busy [2];
  logic [15:0] acc_cnt [2];

  int n_cmp;
  int n_bad;
  logic [15:0] exp_mem [2][65536];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [15:0] mem [65536];
    logic [15:0] hist [LAT];

    zimbo_mem_arbiter #(
      .AW(16), .DW(16), .RD_LAT(LAT), .FIXED_PRI((g == 0) ? 0 : 1)
    ) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
      .addrm(addrm[g]), .wmdata(wmdata[g]), .memwr_en(memwr_en[g]), .rmdata(rmdata[g]),
      .busy(busy[g]), .acc_cnt(acc_cnt[g])
    );

    initial begin
      for (int a = 0; a < 65536; a++) mem[a] = a[15:0] ^ 16'hA5A5;
      mem[16'h0010] = 16'hBEEF;
      for (int k = 0; k < LAT; k++) hist[k] = 16'h0000;
    end

    // Single-port memory: rmdata reflects the address presented LAT cycles earlier.
    always @(posedge clock) begin
      if (memwr_en[g]) mem[addrm[g]] <= wmdata[g];
      hist[0] <= addrm[g];
      for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
    end
    assign rmdata[g] = mem[hist[LAT-1]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic note_accept(input int i, input logic m, input logic we,
                             input logic [15:0] a, input logic [15:0] d);
    if (we) exp_mem[i][a] = d;
    else if (i == 0) q0.push_back({m, exp_mem[i][a]});
    else q1.push_back({m, exp_mem[i][a]});
  endtask

  task automatic note_return(input int i, input logic m, input logic [15:0] data);
    logic [16:0] e;
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rvalid inst%0d m%0d: got rvalid=1 required 0", i, m);
    end else begin
      if (i == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("rd_owner_inst%0d", i), 32'(m), 32'(e[16]));
      chk($sformatf("rd_data_inst%0d", i), 32'(data), 32'(e[15:0]));
    end
  endtask

  // Monitor: check returning reads against the scoreboard, then log new accepts.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gnt_excl_inst%0d", i), 32'(m0_gnt[i] && m1_gnt[i]), 32'd0);
      if (m0_rvalid[i] && m1_rvalid[i]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_excl inst%0d: got both rvalid required one", i);
      end
      if (m0_rvalid[i]) note_return(i, 1'b0, m0_rdata[i]);
      if (m1_rvalid[i]) note_return(i, 1'b1, m1_rdata[i]);
      if (m0_gnt[i]) note_accept(i, 1'b0, m0_we[i], m0_addr[i], m0_wdata[i]);
      if (m1_gnt[i]) note_accept(i, 1'b1, m1_we[i], m1_addr[i], m1_wdata[i]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input int i, input int m, input logic req, input logic we,
                     input logic [15:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_req[i] = req; m0_we[i] = we; m0_addr[i] = a; m0_wdata[i] = d;
    end else begin
      m1_req[i] = req; m1_we[i] = we; m1_addr[i] = a; m1_wdata[i] = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 65536; a++) exp_mem[i][a] = a[15:0] ^ 16'hA5A5;
      exp_mem[i][16'h0010] = 16'hBEEF;
      drv(i, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      drv(i, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    reset = 1'b1;
    cyc();
    cyc();

    // Reset values, with requests present while reset is high
    m0_req[0] = 1'b1;
    m1_req[1] = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_m0_gnt", 32'(m0_gnt[i]), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt[i]), 32'd0);
      chk("rst_addrm", 32'(addrm[i]), 32'h0000);
      chk("rst_wmdata", 32'(wmdata[i]), 32'h0000);
      chk("rst_memwr_en", 32'(memwr_en[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_acc_cnt", 32'(acc_cnt[i]), 32'd0);
      chk("rst_rvalid", 32'({m0_rvalid[i], m1_rvalid[i]}), 32'd0);
    end
    cyc();
    m0_req[0] = 1'b0;
    m1_req[1] = 1'b0;
    reset = 1'b0;

    // m0 read of 0x0010 on the RD_LAT=1 instance
    drv(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clock);
    chk("rd_m0_gnt", 32'(m0_gnt[0]), 32'd1);
    chk("rd_m1_gnt", 32'(m1_gnt[0]), 32'd0);
    cyc();
    drv(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    chk("rd_addrm", 32'(addrm[0]), 32'h0010);
    chk("rd_memwr_en", 32'(memwr_en[0]), 32'd0);
    chk("rd_busy", 32'(busy[0]), 32'd1);
    chk("rd_acc_cnt", 32'(acc_cnt[0]), 32'd1);
    cyc();
    @(negedge clock);
    chk("rd_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
    chk("rd_m0_rdata", 32'(m0_rdata[0]), 32'hBEEF);
    chk("rd_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);

    // m1 write 0x0020 <- 0x1234, then m0 read of the same address
    cyc();
    drv(0, 1, 1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clock);
    chk("wr_m1_gnt", 32'(m1_gnt[0]), 32'd1);
    cyc();
    drv(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    drv(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0);
    @(negedge clock);
    chk("raw_m0_gnt", 32'(m0_gnt[0]), 32'd1);
    chk("wr_memwr_en", 32'(memwr_en[0]), 32'd1);
    chk("wr_addrm", 32'(addrm[0]), 32'h0020);
    chk("wr_wmdata", 32'(wmdata[0]), 32'h1234);
    cyc();
    drv(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    chk("wr_pulse_end", 32'(memwr_en[0]), 32'd0);
    chk("raw_addrm", 32'(addrm[0]), 32'h0020);
    cyc();
    @(negedge clock);
    chk("raw_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
    chk("raw_m0_rdata", 32'(m0_rdata[0]), 32'h1234);
    repeat (3) cyc();

    // Both masters request continuously; fresh reset puts m0 first
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv(i, 0, 1'b1, 1'b0, 16'h0100, 16'h0);
      drv(i, 1, 1'b1, 1'b0, 16'h0200, 16'h0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("rr_m0_gnt_c%0d", k), 32'(m0_gnt[0]), 32'(k % 2 == 0));
      chk($sformatf("rr_m1_gnt_c%0d", k), 32'(m1_gnt[0]), 32'(k % 2 == 1));
      chk($sformatf("fp_m0_gnt_c%0d", k), 32'(m0_gnt[1]), 32'd1);
      chk($sformatf("fp_m1_gnt_c%0d", k), 32'(m1_gnt[1]), 32'd0);
      cyc();
    end
    for (int i = 0; i < 2; i++) drv(i, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    chk("fp_m1_after_drop", 32'(m1_gnt[1]), 32'd1);
    chk("rr_m1_after_drop", 32'(m1_gnt[0]), 32'd1);
    cyc();
    for (int i = 0; i < 2; i++) drv(i, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    chk("rr_acc_cnt", 32'(acc_cnt[0]), 32'd9);
    chk("fp_acc_cnt", 32'(acc_cnt[1]), 32'd9);
    repeat (6) cyc();

    // RD_LAT=3: three m1 reads, then reset two cycles after the last accept
    for (int k = 1; k <= 3; k++) begin
      drv(1, 1, 1'b1, 1'b0, k[15:0], 16'h0);
      @(negedge clock);
      chk($sformatf("lat3_m1_gnt_%0d", k), 32'(m1_gnt[1]), 32'd1);
      cyc();
    end
    drv(1, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("lat3_discarded", 32'(q1.size()), 32'd2);
    q1.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("lat3_busy", 32'(busy[1]), 32'd0);
    chk("lat3_memwr_en", 32'(memwr_en[1]), 32'd0);
    chk("lat3_m1_rvalid", 32'(m1_rvalid[1]), 32'd0);
    chk("lat3_acc_cnt", 32'(acc_cnt[1]), 32'd0);
    repeat (6) cyc();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zimbo_mem_arbiter.md
Name: zimbo_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port memory (mem_top: addrm / wmdata / memwr_en / rmdata) between the Zimbo core (m0) and a second master (m1), such as a program loader, debug port or DMA engine.
- Accepts one access per cycle using a valid/grant handshake and drives registered memory-side signals.
- Returns read data to the requester that issued the read, after a fixed memory read latency.

Parameters:
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles, from addrm presented to rmdata valid; legal range 1..4
- FIXED_PRI, 0, 0 = round-robin; 1 = m0 always wins

Ports:
- clock  in  1  system clock; all state on the rising edge
- reset  in  1  synchronous, active-high
- m0_req  in  1  m0 access request
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  m0 address
- m0_wdata  in  DW  m0 write data
- m0_gnt  out  1  m0 request accepted this cycle (combinational)
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  DW  m0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1
- addrm  out  AW  memory address (registered)
- wmdata  out  DW  memory write data (registered)
- memwr_en  out  1  memory write strobe (registered)
- rmdata  in  DW  memory read data
- busy  out  1  at least one read is in flight
- acc_cnt  out  16  accepted-access counter, wraps

Behaviour:
- Reset values (reset sampled high at an edge):
  - addrm = 0, wmdata = 0, memwr_en = 0.
  - Read pipeline cleared: all valid bits 0, so m0_rvalid = m1_rvalid = 0 and busy = 0.
  - Round-robin pointer set so m0 has priority first.
  - acc_cnt = 0.
  - While reset is high, m0_gnt = m1_gnt = 0.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - A transfer occurs on the edge where req && gnt.
  - A requester may present a new request in the next cycle; back-to-back accepts from the same master are allowed.
  - Dropping req before gnt withdraws the request; no side effects.
- Grant logic (combinational from req and pointer):
  - Only one request: it is granted.
  - Both requests, FIXED_PRI=1: m0 is granted.
  - Both requests, FIXED_PRI=0: the master indicated by the pointer is granted.
  - Pointer update: after any accept, the pointer moves to the other master. With no accept, it holds.
  - At most one gnt is high in any cycle.
- Issue (cycle t = accept edge):
  - In cycle t+1: addrm = winner addr, wmdata = winner wdata, memwr_en = winner we.
  - memwr_en is high for exactly one cycle per accepted write.
  - With no accept: memwr_en = 0, while addrm and wmdata hold their last values.
- Read return:
  - Each accepted read pushes {valid=1, owner} into an RD_LAT-deep shift register; writes push valid=0.
  - When the entry emerges, in cycle t+1+RD_LAT, the owner's rvalid = 1 for one cycle and its rdata = rmdata, passed through combinationally.
  - The non-owner's rvalid = 0; its rdata = rmdata, don't-care.
- busy = OR of the pipeline valid bits.
- acc_cnt increments by 1 per accept and wraps 0xFFFF -> 0x0000.
- Simultaneous events:
  - A write accepted in the same cycle that an earlier read returns: both proceed independently.
  - A read accepted immediately after a write to the same address sees the written data; memory ordering is preserved because issue is strictly in order.
- Reset mid-operation: in-flight reads are discarded; no rvalid pulse occurs after the reset edge.
- No bounds checking on addresses; the full AW range passes through.

Test Plan:
- Reset -> addrm = 0x0000, wmdata = 0x0000, memwr_en = 0, busy = 0, acc_cnt = 0, both gnt and both rvalid = 0.
- m0 read at 0x0010, memory holds 0xBEEF, RD_LAT=1 -> m0_gnt in cycle t; addrm = 0x0010 in t+1; m0_rvalid = 1 with m0_rdata = 0xBEEF in t+2; m1_rvalid stays 0; acc_cnt = 1.
- m1 write 0x0020 <- 0x1234, then m0 read 0x0020 in the next cycle -> memwr_en = 1 for exactly one cycle with addrm = 0x0020, wmdata = 0x1234; m0 receives 0x1234 on rvalid.
- Both masters request continuously for 8 cycles, FIXED_PRI=0 -> grants alternate m0,m1,m0,m1,...; 4 accepts each; never two gnts in one cycle.
- Same stimulus with FIXED_PRI=1 -> m0_gnt every cycle and m1_gnt never; m1 is granted in the first cycle after m0_req drops.
- RD_LAT=3: m1 issues reads to 0x0001..0x0003 back-to-back, then reset asserts 2 cycles after the last accept -> no m1_rvalid after the reset edge; busy = 0; memwr_en = 0.
